// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter.
// Frame = start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Each bit is held for clk_freq/baud_rate clocks. All outputs are registered.
module uart_tx #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CPB_RAW = clk_freq / baud_rate;
  localparam int CPB     = (CPB_RAW < 1) ? 1 : CPB_RAW;
  localparam int CW      = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  // Any stop-bit setting other than 2 gives a single stop bit.
  localparam logic [2:0] STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    sh, sh_n;
  logic          par, par_n;
  logic          tx_n, ready_n, busy_n, done_n;
  logic          bit_end;

  assign bit_end = (cnt == CNT_LAST);

  // State, datapath and output registers; reset drops any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_n;
      sh       <= sh_n;
      par      <= par_n;
      tx       <= tx_n;
      tx_ready <= ready_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Next-state and next-output logic; outputs change only at bit boundaries.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    sh_n    = sh;
    par_n   = par;
    tx_n    = tx;
    ready_n = tx_ready;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        tx_n    = 1'b1;
        ready_n = 1'b1;
        busy_n  = 1'b0;
        if (tx_valid) begin
          sh_n    = tx_data;
          par_n   = (^tx_data) ^ (PARITY_ODD != 0);
          state_n = START;
          cnt_n   = '0;
          bit_n   = '0;
          tx_n    = 1'b0;
          ready_n = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = DATA;
          tx_n    = sh[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          sh_n  = {1'b0, sh[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_n = '0;
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              tx_n    = par;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
            tx_n  = sh[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_n   = '0;
            state_n = IDLE;
            tx_n    = 1'b1;
            ready_n = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitter instances (default 8N1 at 104 clk/bit,
// 8E1 and 8O2 at 16 clk/bit) checked clock by clock against an expected
// line waveform built from the frame format.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dat [3];
  logic       vld [3];
  logic       txw [3];
  logic       rdy [3];
  logic       bsy [3];
  logic       dne [3];

  int cpb   [3] = '{104, 16, 16};
  int pen   [3] = '{0, 1, 1};
  int podd  [3] = '{0, 0, 1};
  int nstop [3] = '{1, 1, 2};

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  uart_tx u0 (
    .clk(clk), .rst(rst), .tx_data(dat[0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx(txw[0]), .busy(bsy[0]), .done(dne[0])
  );

  uart_tx #(.clk_freq(1000000), .baud_rate(62500), .PARITY_EN(1),
            .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_data(dat[1]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx(txw[1]), .busy(bsy[1]), .done(dne[1])
  );

  uart_tx #(.clk_freq(1000000), .baud_rate(62500), .PARITY_EN(1),
            .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .tx_data(dat[2]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx(txw[2]), .busy(bsy[2]), .done(dne[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Sends byte b on instance u starting at a negedge with tx_ready high.
  // Returns at the negedge of the done cycle. chain keeps tx_valid high
  // with nb presented; glitch >= 0 pulses tx_valid with 0xFF at that cycle.
  task automatic frame(input int u, input logic [7:0] b, input bit chain,
                       input logic [7:0] nb, input int glitch);
    logic q[$];
    int   n;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
    if (pen[u] != 0) q.push_back((^b) ^ (podd[u] != 0));
    for (int s = 0; s < nstop[u]; s++) q.push_back(1'b1);
    n = q.size() * cpb[u];
    chk("ready_before", rdy[u], 1);
    dat[u] = b;
    vld[u] = 1'b1;
    @(negedge clk);
    if (chain) dat[u] = nb;
    else vld[u] = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (glitch >= 0 && k == glitch) begin
        vld[u] = 1'b1;
        dat[u] = 8'hFF;
      end else if (glitch >= 0 && k == glitch + 1) begin
        vld[u] = 1'b0;
      end
      chk("tx_line", txw[u], q[k / cpb[u]]);
      chk("busy_frame", bsy[u], 1);
      chk("ready_frame", rdy[u], 0);
      chk("done_frame", dne[u], 0);
      @(negedge clk);
    end
    chk("done_pulse", dne[u], 1);
    chk("ready_after", rdy[u], 1);
    chk("busy_after", bsy[u], 0);
    chk("tx_after", txw[u], 1);
  endtask

  task automatic done_clears(input int u);
    @(negedge clk);
    chk("done_clear", dne[u], 0);
    chk("tx_idle", txw[u], 1);
  endtask

  initial begin
    logic [7:0] c3;
    logic [7:0] rb;
    logic [7:0] rb2;
    for (int u = 0; u < 3; u++) begin
      dat[u] = 8'h00;
      vld[u] = 1'b0;
    end
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst_tx", txw[u], 1);
      chk("rst_ready", rdy[u], 1);
      chk("rst_busy", bsy[u], 0);
      chk("rst_done", dne[u], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // 8N1, 0xA5
    frame(0, 8'hA5, 1'b0, 8'h00, -1);
    done_clears(0);

    // back-to-back 0x55 then 0xAA: second accepted in the done cycle
    frame(0, 8'h55, 1'b1, 8'hAA, -1);
    frame(0, 8'hAA, 1'b0, 8'h00, -1);
    done_clears(0);

    // valid pulse with 0xFF mid-frame is ignored; no extra frame
    frame(0, 8'h3C, 1'b0, 8'h00, 300);
    done_clears(0);
    for (int k = 0; k < 2 * cpb[0]; k++) begin
      chk("no_extra_tx", txw[0], 1);
      chk("no_extra_busy", bsy[0], 0);
      @(negedge clk);
    end

    // reset during data bit 3 of 0xC3
    c3 = 8'hC3;
    dat[0] = c3;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    for (int k = 0; k < 4 * cpb[0] + 50; k++) begin
      chk("tx_pre_rst", txw[0], (k < cpb[0]) ? 1'b0 : c3[k / cpb[0] - 1]);
      @(negedge clk);
    end
    chk("tx_bit3_low", txw[0], 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", txw[0], 1);
    chk("rst_mid_ready", rdy[0], 1);
    chk("rst_mid_busy", bsy[0], 0);
    chk("rst_mid_done", dne[0], 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12 * cpb[0]; k++) begin
      chk("no_done_abort", dne[0], 0);
      chk("idle_after_rst", txw[0], 1);
      @(negedge clk);
    end
    frame(0, 8'h81, 1'b0, 8'h00, -1);
    done_clears(0);

    // even parity, one stop bit
    frame(1, 8'hA5, 1'b0, 8'h00, -1);
    done_clears(1);
    frame(1, 8'h07, 1'b0, 8'h00, -1);
    done_clears(1);

    // odd parity, two stop bits
    frame(2, 8'hA5, 1'b0, 8'h00, -1);
    done_clears(2);
    frame(2, 8'h00, 1'b0, 8'h00, -1);
    done_clears(2);

    // randomized bytes on every configuration, including a chained pair
    for (int r = 0; r < 4; r++) begin
      for (int u = 0; u < 3; u++) begin
        rb  = 8'($urandom_range(0, 255));
        rb2 = 8'($urandom_range(0, 255));
        if ((r & 1) != 0) begin
          frame(u, rb, 1'b1, rb2, -1);
          frame(u, rb2, 1'b0, 8'h00, -1);
        end else begin
          frame(u, rb, 1'b0, 8'h00, -1);
        end
        done_clears(u);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
